// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives imem, fills the IF/ID register.
// Out-of-range or misaligned PCs park the stage in FAULT until a redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fault_d,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FAULT = 2'd2;

  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [1:0]  state;
  logic [31:0] pc_f;
  logic [31:0] pc_inc;
  logic        bad_pc;

  assign imem_addr = pc_f;
  assign pc_inc    = pc_f + 32'd4;
  assign bad_pc    = ({1'b0, pc_f} >= LIMIT)
                   || (pc_f[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pc_f        <= RESET_PC;
      instr_d     <= NOP_INSTR;
      pc_d        <= 32'd0;
      pc_plus4_d  <= 32'd0;
      valid_d     <= 1'b0;
      fault_d     <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      unique case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (bad_pc) begin
            // Fault bubble records where the bad fetch was attempted
            state      <= FAULT;
            instr_d    <= NOP_INSTR;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_inc;
            valid_d    <= 1'b0;
            fault_d    <= 1'b1;
          end else begin
            priority case (1'b1)
              redirect: pc_f <= redirect_target;
              stall_f:  pc_f <= pc_f;
              default:  pc_f <= pc_inc;
            endcase
            priority case (1'b1)
              flush_d, redirect: begin
                instr_d <= NOP_INSTR;
                valid_d <= 1'b0;
                fault_d <= 1'b0;
              end
              stall_d: begin
                instr_d <= instr_d;
              end
              default: begin
                instr_d     <= imem_rdata;
                pc_d        <= pc_f;
                pc_plus4_d  <= pc_inc;
                valid_d     <= 1'b1;
                fault_d     <= 1'b0;
                fetch_count <= fetch_count + 32'd1;
              end
            endcase
          end
        end
        FAULT: begin
          if (redirect) begin
            state   <= RUN;
            pc_f    <= redirect_target;
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
            fault_d <= 1'b0;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit against a cycle-level reference model.
// Stimulus pushes expected IF/ID snapshots; a monitor pops and compares.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int unsigned WORDS = 1024;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        fault_d;
  logic [31:0] fetch_count;

  logic [31:0] mem [WORDS];

  instr_fetch_unit #(
    .RESET_PC(32'h0),
    .IMEM_WORDS(WORDS),
    .NOP_INSTR(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .stall_f(stall_f),
    .stall_d(stall_d),
    .flush_d(flush_d),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .instr_d(instr_d),
    .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d),
    .fault_d(fault_d),
    .fetch_count(fetch_count)
  );

  assign imem_rdata = (imem_addr < WORDS * 4)
    ? mem[imem_addr[11:2]] : 32'hBAD0_BAD0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pc4;
    logic        valid;
    logic        fault;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_boot;
  bit          m_fault;
  logic [31:0] m_pc;
  exp_t        m;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit fetchable(input logic [31:0] a);
    return (a < WORDS * 4) && (a[1:0] == 2'b00);
  endfunction

  task automatic model_reset();
    m_boot  = 1;
    m_fault = 0;
    m_pc    = 32'h0;
    m.instr = NOP;
    m.pcd   = 0;
    m.pc4   = 0;
    m.valid = 0;
    m.fault = 0;
    m.count = 0;
  endtask

  // advance the model by one clock with the currently driven inputs
  task automatic step_push();
    logic [31:0] next_pc;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_fault) begin
      if (redirect) begin
        m_pc    = redirect_target;
        m_fault = 0;
        m.instr = NOP;
        m.valid = 0;
        m.fault = 0;
      end
    end else if (!fetchable(m_pc)) begin
      m_fault = 1;
      m.instr = NOP;
      m.pcd   = m_pc;
      m.pc4   = m_pc + 4;
      m.valid = 0;
      m.fault = 1;
    end else begin
      if (redirect) next_pc = redirect_target;
      else if (stall_f) next_pc = m_pc;
      else next_pc = m_pc + 4;
      if (flush_d || redirect) begin
        m.instr = NOP;
        m.valid = 0;
        m.fault = 0;
      end else if (!stall_d) begin
        m.instr = mem[m_pc[11:2]];
        m.pcd   = m_pc;
        m.pc4   = m_pc + 4;
        m.valid = 1;
        m.fault = 0;
        m.count = m.count + 1;
      end
      m_pc = next_pc;
    end
    m.pc = m_pc;
    sb.push_back(m);
  endtask

  task automatic drive(input bit sf, input bit sd,
                       input bit fl, input bit rd,
                       input logic [31:0] tg);
    @(negedge clk);
    stall_f = sf;
    stall_d = sd;
    flush_d = fl;
    redirect = rd;
    redirect_target = tg;
    step_push();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pcd", pc_d, 32'h0);
    chk("rst_pc4", pc_plus4_d, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_fault", {31'd0, fault_d}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
  endtask

  // monitor: every clock, compare DUT against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("pc_f", imem_addr, e.pc);
        chk("instr_d", instr_d, e.instr);
        chk("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
        chk("fault_d", {31'd0, fault_d}, {31'd0, e.fault});
        chk("count", fetch_count, e.count);
        if (e.valid || e.fault) begin
          chk("pc_d", pc_d, e.pcd);
          chk("pc_plus4_d", pc_plus4_d, e.pc4);
        end
      end
    end
  end

  initial begin
    logic [31:0] tg;
    int r;
    for (int i = 0; i < WORDS; i++) mem[i] = $urandom;
    rst = 0;
    stall_f = 0;
    stall_d = 0;
    flush_d = 0;
    redirect = 0;
    redirect_target = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals();

    // release: BOOT then sequential fetch
    @(negedge clk);
    rst = 1;
    step_push();
    idle(4);
    // stall both stages, then resume
    drive(1, 1, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    idle(2);
    // redirect with stall_f wins
    drive(1, 0, 0, 1, 32'h40);
    idle(3);
    // out-of-range redirect, frozen fault, recovery
    drive(0, 0, 0, 1, 32'h1000);
    for (int i = 0; i < 10; i++)
      drive($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0);
    drive(0, 0, 0, 1, 32'h0);
    idle(3);
    // misaligned redirect
    drive(0, 0, 0, 1, 32'h6);
    idle(3);
    drive(0, 0, 0, 1, 32'h100);
    idle(2);
    drive(0, 0, 1, 0, 0);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      tg = $urandom_range(0, 255) << 2;
      if (r < 3) tg = 32'h1000 + ($urandom_range(0, 15) << 2);
      else if (r < 6) tg = tg | $urandom_range(1, 3);
      else if (r < 7) tg = 32'hFFFF_FFFC;
      else if (r < 9) tg = (WORDS - 2) * 4;
      drive($urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 9) == 0,
            tg);
    end

    // mid-run async reset
    drive(0, 0, 0, 1, 32'h20);
    idle(3);
    @(posedge clk);
    #2;
    @(negedge clk);
    #2;
    rst = 0;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk);
    rst = 1;
    step_push();
    idle(5);
    @(posedge clk);
    #3;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the instruction memory read port.
- Owns the program counter and drives the byte address to instruction memory each cycle.
- Captures the returned word into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from the hazard unit and EX stage, traps out-of-range fetches, and counts delivered instructions.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_WORDS, 1024, instruction memory depth in 32-bit words; valid byte range is 0 to IMEM_WORDS*4-1
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on flush, reset and fault

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
imem_addr  out  32  byte address to instruction memory; word index = imem_addr[31:2]
imem_rdata  in  32  combinational read data for imem_addr (same cycle)
stall_f  in  1  hold PC (load-use hazard)
stall_d  in  1  hold IF/ID register
flush_d  in  1  replace IF/ID contents with bubble
redirect  in  1  branch taken / jump from EX
redirect_target  in  32  new PC when redirect=1
instr_d  out  32  IF/ID instruction
pc_d  out  32  IF/ID PC
pc_plus4_d  out  32  IF/ID PC+4
valid_d  out  1  IF/ID holds a real instruction
fault_d  out  1  IF/ID entry came from misaligned or out-of-range PC
fetch_count  out  32  number of valid instructions accepted into IF/ID

Behaviour:
- Reset (rst=0, async)
  - pc_f=RESET_PC, state=BOOT.
  - instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fault_d=0, fetch_count=0.
- imem_addr = pc_f at all times, combinational from the register.
- FSM states and transitions:
  - BOOT: exactly one cycle after rst deasserts. No capture; IF/ID keeps its reset values. Next state RUN.
  - RUN: normal fetch. Enter FAULT when pc_f >= IMEM_WORDS*4 or pc_f[1:0]!=0.
  - FAULT: on entry, IF/ID is loaded with NOP_INSTR, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=0, fault_d=1. PC then holds. Exit only on redirect: load target, go to RUN. stall_f/stall_d are ignored in FAULT.
- PC update priority (RUN): redirect > stall_f > increment.
  - redirect=1: pc_f<=redirect_target, regardless of stall_f.
  - else stall_f=1: hold.
  - else: pc_f<=pc_f+4, modulo 2^32 (0xFFFFFFFC wraps to 0).
- IF/ID update priority (RUN): flush_d > redirect > stall_d > capture.
  - flush_d=1 or redirect=1: bubble, i.e. instr_d=NOP_INSTR, valid_d=0, fault_d=0. pc_d/pc_plus4_d are don't-care; hold them.
  - stall_d=1: hold all IF/ID outputs.
  - capture: instr_d=imem_rdata, pc_d=pc_f, pc_plus4_d=pc_f+4, valid_d=1, fault_d=0.
- A misaligned redirect_target is accepted into pc_f. The fault is raised the following cycle through the RUN→FAULT rule, and no instruction from that address is ever captured.
- fetch_count increments by 1 on every capture with valid_d<=1. It wraps at 2^32 and is not cleared by flush or fault.
- Latency: an instruction at PC p appears on instr_d one clock after pc_f=p, with no stalls.
- rst asserted mid-operation (any state) returns immediately to the reset values. No partial capture.

Test Plan:
- Reset release, stalls and flush idle, imem[0..3]=A,B,C,D: cycle 1 after release valid_d=0 (BOOT); then instr_d=A/pc_d=0, B/4, C/8, D/0xC on consecutive cycles; fetch_count=4.
- stall_f=stall_d=1 for 2 cycles while pc_f=8: instr_d holds B, pc_f holds 8, fetch_count unchanged; on release C then D follow.
- redirect=1, target=0x40, same cycle as stall_f=1: next cycle pc_f=0x40, instr_d=NOP_INSTR, valid_d=0; next capture instr_d=imem[16], pc_d=0x40.
- Redirect to 0x1000 with IMEM_WORDS=1024: FAULT entered; instr_d=NOP, pc_d=0x1000, fault_d=1, valid_d=0; PC frozen 10 cycles; redirect to 0x0 resumes with instr_d=imem[0].
- Redirect to 0x6 (misaligned): next cycle fault_d=1, pc_d=0x6; imem_rdata never captured as valid.
- Assert rst for 1 cycle while in RUN at pc_f=0x20, fetch_count=8: outputs return to reset values asynchronously, pc_f=RESET_PC, fetch_count=0, BOOT repeats.
